pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_reg_if.sv | 30 +++
 rtl/hazard_countdown.sv | 28 ++
 rtl/pipe_stage_reg.sv | 69 ++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline-stage registers.
package pipe_pkg;

    // What a stage register does while the hazard logic holds it back.
    typedef enum logic {
        HOLD   = 1'b0,
        BUBBLE = 1'b1
    } stall_mode_e;

    // Packed control bundle; side-effecting enables live in the low bits.
    typedef struct packed {
        logic [21:0] misc;
        logic [2:0]  load_sel;
        logic [2:0]  pc_mux_sel;
        logic        mem_write_en;
        logic        lo_en;
        logic        hi_en;
        logic        ctrl_we;
    } ctrl_t;

    localparam int CTRL_BUS_W = $bits(ctrl_t);

    // Kill masks per stage boundary: set bits are zeroed on a bubble.
    localparam logic [CTRL_BUS_W-1:0] KILL_IF_ID  = {CTRL_BUS_W{1'b1}};
    localparam logic [CTRL_BUS_W-1:0] KILL_ID_EX  = 32'h0000_007F;
    localparam logic [CTRL_BUS_W-1:0] KILL_EX_MEM = 32'h0000_038F;
    localparam logic [CTRL_BUS_W-1:0] KILL_MEM_WB = 32'h0000_0007;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle between a pipeline stage register and its neighbours.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 32,
    parameter int CD_W   = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              cd_load;
    logic [CD_W-1:0]   cd_amt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              stall_out;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, stall, flush, cd_load, cd_amt,
        input  out_valid, out_data, out_ctrl, stall_out, bubble_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, stall, flush, cd_load, cd_amt,
        output out_valid, out_data, out_ctrl, stall_out, bubble_cnt
    );
endinterface

// File: rtl/hazard_countdown.sv
// Loadable down-counter that keeps a stage stalled for a fixed number of cycles.
module hazard_countdown #(
    parameter int CD_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cd_load,
    input  logic [CD_W-1:0] cd_amt,
    input  logic            flush,
    output logic            busy
);
    logic [CD_W-1:0] cd_q;

    // Flush cancels any pending stall; a load always restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_q <= '0;
        end else if (flush) begin
            cd_q <= '0;
        end else if (cd_load) begin
            cd_q <= cd_amt;
        end else if (cd_q != '0) begin
            cd_q <= cd_q - 1'b1;
        end
    end

    assign busy = (cd_q != '0);
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with hold/flush/bubble, hazard countdown and bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 64,
    parameter int                 CTRL_W     = CTRL_BUS_W,
    parameter logic [CTRL_W-1:0]  KILL_MASK  = {CTRL_W{1'b1}},
    parameter logic [DATA_W-1:0]  RESET_DATA = '0,
    parameter stall_mode_e        STALL_MODE = HOLD,
    parameter int                 CD_W       = 3,
    parameter int                 CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);
    logic              cd_busy;
    logic              eff_stall;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  bubble_q;

    hazard_countdown #(
        .CD_W (CD_W)
    ) u_countdown (
        .clk     (clk),
        .rst     (rst),
        .cd_load (bus.cd_load),
        .cd_amt  (bus.cd_amt),
        .flush   (bus.flush),
        .busy    (cd_busy)
    );

    assign eff_stall = bus.stall | cd_busy;

    // Flush beats stall; a stall either freezes the stage or injects a counted bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= RESET_DATA;
            ctrl_q   <= '0;
            bubble_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
            ctrl_q  <= '0;
        end else if (eff_stall) begin
            if (STALL_MODE == BUBBLE) begin
                valid_q <= 1'b0;
                data_q  <= bus.in_data;
                ctrl_q  <= bus.in_ctrl & ~KILL_MASK;
                if (bubble_q != {CNT_W{1'b1}}) begin
                    bubble_q <= bubble_q + 1'b1;
                end
            end
        end else begin
            valid_q <= bus.in_valid;
            data_q  <= bus.in_data;
            ctrl_q  <= bus.in_ctrl;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.out_ctrl   = ctrl_q;
    assign bus.stall_out  = eff_stall;
    assign bus.bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one hold-mode and one bubble-mode stage driven in lockstep.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [31:0] in_ctrl;
    logic        stall;
    logic        flush;
    logic        cd_load;
    logic [2:0]  cd_amt;

    int checks;
    int errors;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(32), .CD_W(3), .CNT_W(16)) h_bus ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(32), .CD_W(3), .CNT_W(2))  b_bus ();

    assign h_bus.in_valid = in_valid;
    assign h_bus.in_data  = in_data;
    assign h_bus.in_ctrl  = in_ctrl;
    assign h_bus.stall    = stall;
    assign h_bus.flush    = flush;
    assign h_bus.cd_load  = cd_load;
    assign h_bus.cd_amt   = cd_amt;

    assign b_bus.in_valid = in_valid;
    assign b_bus.in_data  = in_data;
    assign b_bus.in_ctrl  = in_ctrl;
    assign b_bus.stall    = stall;
    assign b_bus.flush    = flush;
    assign b_bus.cd_load  = cd_load;
    assign b_bus.cd_amt   = cd_amt;

    pipe_stage_reg #(
        .DATA_W     (64),
        .CTRL_W     (32),
        .KILL_MASK  (32'hFFFF_FFFF),
        .RESET_DATA (64'h0),
        .STALL_MODE (HOLD),
        .CD_W       (3),
        .CNT_W      (16)
    ) u_hold (
        .clk (clk),
        .rst (rst),
        .bus (h_bus)
    );

    pipe_stage_reg #(
        .DATA_W     (64),
        .CTRL_W     (32),
        .KILL_MASK  (32'h0000_000F),
        .RESET_DATA (64'hDEAD),
        .STALL_MODE (BUBBLE),
        .CD_W       (3),
        .CNT_W      (2)
    ) u_bub (
        .clk (clk),
        .rst (rst),
        .bus (b_bus)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic [31:0] c,
                                  input logic s, input logic f, input logic ld,
                                  input logic [2:0] amt);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        stall    = s;
        flush    = f;
        cd_load  = ld;
        cd_amt   = amt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_output("rst_h_valid", 64'(h_bus.out_valid), 64'h0);
        check_output("rst_h_data", h_bus.out_data, 64'h0);
        check_output("rst_h_ctrl", 64'(h_bus.out_ctrl), 64'h0);
        check_output("rst_h_cnt", 64'(h_bus.bubble_cnt), 64'h0);
        check_output("rst_b_data", b_bus.out_data, 64'hDEAD);
        check_output("rst_stall_out", 64'(h_bus.stall_out), 64'h0);

        // Plain passthrough, one cycle latency.
        apply_stimulus(1'b1, 64'h1234, 32'hF0, 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("pre_edge_valid", 64'(h_bus.out_valid), 64'h0);
        step();
        check_output("pass_h_valid", 64'(h_bus.out_valid), 64'h1);
        check_output("pass_h_data", h_bus.out_data, 64'h1234);
        check_output("pass_h_ctrl", 64'(h_bus.out_ctrl), 64'hF0);
        check_output("pass_b_ctrl", 64'(b_bus.out_ctrl), 64'hF0);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check_output("async_h_valid", 64'(h_bus.out_valid), 64'h0);
        check_output("async_h_ctrl", 64'(h_bus.out_ctrl), 64'h0);
        check_output("async_b_data", b_bus.out_data, 64'hDEAD);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("repass_h_data", h_bus.out_data, 64'h1234);

        // Flush against stall and a countdown load.
        apply_stimulus(1'b1, 64'h77, 32'hFF, 1'b1, 1'b1, 1'b1, 3'd5);
        step();
        apply_stimulus(1'b1, 64'h77, 32'hFF, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        check_output("flush_h_valid", 64'(h_bus.out_valid), 64'h0);
        check_output("flush_h_data", h_bus.out_data, 64'h0);
        check_output("flush_h_ctrl", 64'(h_bus.out_ctrl), 64'h0);
        check_output("flush_b_data", b_bus.out_data, 64'hDEAD);
        check_output("flush_b_ctrl", 64'(b_bus.out_ctrl), 64'h0);
        check_output("flush_stall_out", 64'(h_bus.stall_out), 64'h0);
        check_output("flush_b_cnt", 64'(b_bus.bubble_cnt), 64'h0);
        @(negedge clk);

        // Load a known word, then stall with changing inputs.
        apply_stimulus(1'b1, 64'hAA, 32'h3C, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        check_output("load_h_data", h_bus.out_data, 64'hAA);
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(1'b1, 64'h100 + 64'(i), 32'hFF, 1'b1, 1'b0, 1'b0, 3'd0);
            #1;
            check_output("stall_out_comb", 64'(h_bus.stall_out), 64'h1);
            @(negedge clk);
            check_output("hold_h_data", h_bus.out_data, 64'hAA);
            check_output("hold_h_valid", 64'(h_bus.out_valid), 64'h1);
            check_output("hold_h_ctrl", 64'(h_bus.out_ctrl), 64'h3C);
            check_output("hold_h_cnt", 64'(h_bus.bubble_cnt), 64'h0);
            check_output("bub_b_valid", 64'(b_bus.out_valid), 64'h0);
            check_output("bub_b_ctrl", 64'(b_bus.out_ctrl), 64'hF0);
            check_output("bub_b_data", b_bus.out_data, 64'h100 + 64'(i));
            check_output("bub_b_cnt", 64'(b_bus.bubble_cnt), (i < 3) ? 64'(i) : 64'd3);
        end

        // Release the stall.
        apply_stimulus(1'b1, 64'h55, 32'h12, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        check_output("release_h_data", h_bus.out_data, 64'h55);
        check_output("release_b_valid", 64'(b_bus.out_valid), 64'h1);
        check_output("release_b_ctrl", 64'(b_bus.out_ctrl), 64'h12);

        // Countdown of 3 loaded at edge 0.
        apply_stimulus(1'b1, 64'h66, 32'h12, 1'b0, 1'b0, 1'b1, 3'd3);
        step();
        apply_stimulus(1'b1, 64'h77, 32'h12, 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("cd_c1_stall", 64'(h_bus.stall_out), 64'h1);
        check_output("cd_c1_data", h_bus.out_data, 64'h66);
        step();
        check_output("cd_c2_stall", 64'(h_bus.stall_out), 64'h1);
        check_output("cd_c2_data", h_bus.out_data, 64'h66);
        step();
        check_output("cd_c3_stall", 64'(h_bus.stall_out), 64'h1);
        step();
        check_output("cd_c4_stall", 64'(h_bus.stall_out), 64'h0);
        check_output("cd_c4_data", h_bus.out_data, 64'h66);
        step();
        check_output("cd_c5_data", h_bus.out_data, 64'h77);

        // Reload 2 while the count sits at 1.
        apply_stimulus(1'b1, 64'h77, 32'h12, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        apply_stimulus(1'b1, 64'h77, 32'h12, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        apply_stimulus(1'b1, 64'h77, 32'h12, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        apply_stimulus(1'b1, 64'h77, 32'h12, 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("reload_c1_stall", 64'(h_bus.stall_out), 64'h1);
        step();
        check_output("reload_c2_stall", 64'(h_bus.stall_out), 64'h1);
        step();
        check_output("reload_c3_stall", 64'(h_bus.stall_out), 64'h0);

        // A zero-distance load never stalls.
        apply_stimulus(1'b1, 64'h88, 32'h12, 1'b0, 1'b0, 1'b1, 3'd0);
        step();
        apply_stimulus(1'b1, 64'h88, 32'h12, 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("cd0_stall", 64'(h_bus.stall_out), 64'h0);
        check_output("cd0_data", h_bus.out_data, 64'h88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
